mul_issue_ctrl: RTL and testbench

//  Sequencer between the execute issue point and the multi-cycle multiply unit.

---
 rtl/mul_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue-side sequencer for the multi-cycle multiplier: holds one MUL-class op,
// runs the operand/result handshakes and presents the tagged result to writeback.
module mul_issue_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush_i,
   input  logic             issue_valid_i,
   output logic             issue_ready_o,
   input  logic [63:0]      issue_opr_a_i,
   input  logic [63:0]      issue_opr_b_i,
   input  logic [3:0]       issue_func_i,
   input  logic             issue_word_i,
   input  logic [4:0]       issue_rd_i,
   output logic             mul_valid_o,
   output logic [63:0]      mul_opr_a_o,
   output logic [63:0]      mul_opr_b_o,
   output logic [3:0]       mul_func_o,
   output logic             mul_word_o,
   input  logic             mul_ready_i,
   input  logic [63:0]      mul_res_i,
   input  logic             mul_res_valid_i,
   output logic             mul_res_ready_o,
   output logic             wb_valid_o,
   output logic [4:0]       wb_rd_o,
   output logic [63:0]      wb_data_o,
   input  logic             wb_ready_i,
   output logic             busy_o,
   output logic [4:0]       busy_rd_o,
   output logic [CNT_W-1:0] done_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_WB   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [63:0]      opr_a_q, opr_a_d;
   logic [63:0]      opr_b_q, opr_b_d;
   logic [3:0]       func_q, func_d;
   logic             word_q, word_d;
   logic [4:0]       rd_q, rd_d;
   logic [63:0]      wb_data_q, wb_data_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic             issue_ready_q, issue_ready_d;

   // Next-state and holding-register update; flush takes priority in every state.
   always_comb begin
      state_d    = state_q;
      opr_a_d    = opr_a_q;
      opr_b_d    = opr_b_q;
      func_d     = func_q;
      word_d     = word_q;
      rd_d       = rd_q;
      wb_data_d  = wb_data_q;
      done_cnt_d = done_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (issue_valid_i && !flush_i) begin
               opr_a_d = issue_opr_a_i;
               opr_b_d = issue_opr_b_i;
               func_d  = issue_func_i;
               word_d  = issue_word_i;
               rd_d    = issue_rd_i;
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (mul_ready_i) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (mul_res_valid_i) begin
               wb_data_d = mul_res_i;
               // Writes to x0 have no architectural effect, so they retire here.
               if (rd_q == 5'd0) begin
                  state_d    = S_IDLE;
                  done_cnt_d = done_cnt_q + CNT_W'(1);
               end else begin
                  state_d = S_WB;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WB: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (wb_ready_i) begin
               state_d    = S_IDLE;
               done_cnt_d = done_cnt_q + CNT_W'(1);
            end else begin
               state_d = S_WB;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Registered so that it reads 0 while reset is asserted.
      issue_ready_d = (state_d == S_IDLE);
   end

   // State, operand, result and counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         opr_a_q       <= 64'd0;
         opr_b_q       <= 64'd0;
         func_q        <= 4'd0;
         word_q        <= 1'b0;
         rd_q          <= 5'd0;
         wb_data_q     <= 64'd0;
         done_cnt_q    <= '0;
         issue_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         opr_a_q       <= opr_a_d;
         opr_b_q       <= opr_b_d;
         func_q        <= func_d;
         word_q        <= word_d;
         rd_q          <= rd_d;
         wb_data_q     <= wb_data_d;
         done_cnt_q    <= done_cnt_d;
         issue_ready_q <= issue_ready_d;
      end
   end

   assign issue_ready_o   = issue_ready_q;
   assign mul_valid_o     = (state_q == S_REQ);
   assign mul_opr_a_o     = opr_a_q;
   assign mul_opr_b_o     = opr_b_q;
   assign mul_func_o      = func_q;
   assign mul_word_o      = word_q;
   assign mul_res_ready_o = (state_q == S_WAIT);
   assign wb_valid_o      = (state_q == S_WB);
   assign wb_rd_o         = rd_q;
   assign wb_data_o       = wb_data_q;
   assign busy_o          = (state_q != S_IDLE);
   assign busy_rd_o       = (state_q != S_IDLE) ? rd_q : 5'd0;
   assign done_cnt_o      = done_cnt_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a behavioural multiplier responder plus directed and
// randomized ops checked against product values computed from the operands.
module tb_mul_issue_ctrl;

   localparam logic [3:0] OP_MUL    = 4'd0;
   localparam logic [3:0] OP_MULH   = 4'd1;
   localparam logic [3:0] OP_MULHSU = 4'd2;
   localparam logic [3:0] OP_MULHU  = 4'd3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush_i = 1'b0;
   logic        issue_valid_i = 1'b0;
   logic        issue_ready_o;
   logic [63:0] issue_opr_a_i = 64'd0;
   logic [63:0] issue_opr_b_i = 64'd0;
   logic [3:0]  issue_func_i = 4'd0;
   logic        issue_word_i = 1'b0;
   logic [4:0]  issue_rd_i = 5'd0;
   logic        mul_valid_o;
   logic [63:0] mul_opr_a_o, mul_opr_b_o;
   logic [3:0]  mul_func_o;
   logic        mul_word_o;
   logic        mul_ready_i;
   logic [63:0] mul_res_i;
   logic        mul_res_valid_i;
   logic        mul_res_ready_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [63:0] wb_data_o;
   logic        wb_ready_i = 1'b0;
   logic        busy_o;
   logic [4:0]  busy_rd_o;
   logic [31:0] done_cnt_o;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int exp_done = 0;

   mul_issue_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .resetn(resetn), .flush_i(flush_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_opr_a_i(issue_opr_a_i), .issue_opr_b_i(issue_opr_b_i),
      .issue_func_i(issue_func_i), .issue_word_i(issue_word_i), .issue_rd_i(issue_rd_i),
      .mul_valid_o(mul_valid_o), .mul_opr_a_o(mul_opr_a_o), .mul_opr_b_o(mul_opr_b_o),
      .mul_func_o(mul_func_o), .mul_word_o(mul_word_o), .mul_ready_i(mul_ready_i),
      .mul_res_i(mul_res_i), .mul_res_valid_i(mul_res_valid_i),
      .mul_res_ready_o(mul_res_ready_o),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .wb_ready_i(wb_ready_i), .busy_o(busy_o), .busy_rd_o(busy_rd_o),
      .done_cnt_o(done_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Product as the multiplier would compute it from the operands.
   function automatic logic [63:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] f, input logic w);
      logic [127:0] p;
      logic [63:0]  lo;
      if (w) begin
         lo = a * b;
         return {{32{lo[31]}}, lo[31:0]};
      end
      case (f)
         OP_MULH:   p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
         OP_MULHSU: p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
         default:   p = {64'd0, a} * {64'd0, b};
      endcase
      return (f == OP_MUL) ? p[63:0] : p[127:64];
   endfunction

   // Multiplier responder: result 2 cycles after accept for word ops, 4 for dword.
   logic        mbusy;
   int          mcnt;
   logic [63:0] mres;
   assign mul_ready_i = !mbusy;
   assign mul_res_i   = mres;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mbusy <= 1'b0; mcnt <= 0; mres <= 64'd0; mul_res_valid_i <= 1'b0;
      end else if (flush_i) begin
         mbusy <= 1'b0; mcnt <= 0; mul_res_valid_i <= 1'b0;
      end else if (!mbusy && mul_valid_o) begin
         mbusy <= 1'b1;
         mcnt  <= mul_word_o ? 1 : 3;
         mres  <= mul_model(mul_opr_a_o, mul_opr_b_o, mul_func_o, mul_word_o);
      end else if (mbusy && mul_res_valid_i && mul_res_ready_o) begin
         mbusy <= 1'b0; mul_res_valid_i <= 1'b0;
      end else if (mbusy && !mul_res_valid_i) begin
         if (mcnt == 1) mul_res_valid_i <= 1'b1;
         mcnt <= mcnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] f,
                        input logic w, input logic [4:0] rd, output int t);
      int n = 0;
      while (!issue_ready_o && n < 50) begin @(negedge clk); n++; end
      chk("issue_ready_idle", 64'(issue_ready_o), 64'd1);
      issue_opr_a_i = a; issue_opr_b_i = b; issue_func_i = f;
      issue_word_i = w; issue_rd_i = rd; issue_valid_i = 1'b1;
      t = cyc;
      @(negedge clk);
      issue_valid_i = 1'b0;
      issue_opr_a_i = ~a;
      chk("mul_valid_next", 64'(mul_valid_o), 64'd1);
      chk("mul_opr_a", mul_opr_a_o, a);
      chk("busy_rd", 64'(busy_rd_o), 64'(rd));
      chk("issue_ready_busy", 64'(issue_ready_o), 64'd0);
   endtask

   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] f,
                        input logic w, input logic [4:0] rd, input int hold, input int lat);
      int t;
      int n = 0;
      logic [63:0] expd;
      expd = mul_model(a, b, f, w);
      issue(a, b, f, w, rd, t);
      while (busy_o && !wb_valid_o && n < 50) begin @(negedge clk); n++; end
      if (rd != 5'd0) begin
         chk("wb_valid", 64'(wb_valid_o), 64'd1);
         if (lat > 0) chk("wb_latency", 64'(cyc - t), 64'(lat));
         chk("wb_rd", 64'(wb_rd_o), 64'(rd));
         chk("wb_data", wb_data_o, expd);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("wb_hold_valid", 64'(wb_valid_o), 64'd1);
            chk("wb_hold_data", wb_data_o, expd);
            chk("wb_hold_rd", 64'(wb_rd_o), 64'(rd));
            chk("wb_hold_ready", 64'(issue_ready_o), 64'd0);
         end
         wb_ready_i = 1'b1;
         @(negedge clk);
         wb_ready_i = 1'b0;
         exp_done++;
         chk("wb_valid_clear", 64'(wb_valid_o), 64'd0);
      end else begin
         chk("rd0_no_wb", 64'(wb_valid_o), 64'd0);
         exp_done++;
      end
      chk("busy_clear", 64'(busy_o), 64'd0);
      chk("busy_rd_clear", 64'(busy_rd_o), 64'd0);
      chk("done_cnt", 64'(done_cnt_o), 64'(exp_done));
   endtask

   task automatic flush_at(input int off);
      int t;
      issue(64'h1234, 64'h5678, OP_MUL, 1'b0, 5'd9, t);
      while (cyc < t + off) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_busy", 64'(busy_o), 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("flush_no_wb", 64'(wb_valid_o), 64'd0);
      end
      chk("flush_done_cnt", 64'(done_cnt_o), 64'(exp_done));
   endtask

   initial begin
      int t;
      repeat (3) @(negedge clk);
      chk("rst_issue_ready", 64'(issue_ready_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
      chk("rst_mul_valid", 64'(mul_valid_o), 64'd0);
      chk("rst_done_cnt", 64'(done_cnt_o), 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      do_op(64'd3, -64'sd5, OP_MUL, 1'b0, 5'd7, 0, 6);
      chk("mul_neg_result", wb_data_o, 64'hFFFF_FFFF_FFFF_FFF1);
      do_op(64'h8000_0000, 64'd2, OP_MUL, 1'b1, 5'd1, 0, 4);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd7, OP_MULHU, 1'b0, 5'd0, 0, 0);
      do_op(-64'sd2, 64'd3, OP_MULH, 1'b0, 5'd4, 10, 6);
      do_op(-64'sd1, 64'hFFFF_FFFF_FFFF_FFFF, OP_MULHSU, 1'b0, 5'd31, 2, 6);

      flush_at(1);
      flush_at(3);
      do_op(64'd11, 64'd13, OP_MUL, 1'b0, 5'd5, 0, 6);
      flush_at(6);

      for (int k = 0; k < 40; k++) begin
         logic [63:0] ra, rb;
         logic        rw;
         logic [4:0]  rrd;
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         rw  = 1'($urandom_range(0, 1));
         rrd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         do_op(ra, rb, 4'($urandom_range(0, 3)), rw, rrd, $urandom_range(0, 3), rw ? 4 : 6);
      end

      issue(64'hDEAD, 64'hBEEF, OP_MUL, 1'b0, 5'd12, t);
      #2;
      resetn = 1'b0;
      #1;
      exp_done = 0;
      chk("arst_mul_valid", 64'(mul_valid_o), 64'd0);
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_busy_rd", 64'(busy_rd_o), 64'd0);
      chk("arst_issue_ready", 64'(issue_ready_o), 64'd0);
      chk("arst_opr_a", mul_opr_a_o, 64'd0);
      chk("arst_done_cnt", 64'(done_cnt_o), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      do_op(64'd6, 64'd7, OP_MUL, 1'b1, 5'd2, 1, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
